// File: rtl/imem_loader.sv
// Fills a writable instruction memory from a byte stream, with a trailing XOR checksum; holds the core in reset until a clean load.
// Latency: write pulse one cycle after a word's last byte; DONE/ERR one cycle after the checksum byte.
// Backpressure: byte_ready high only in LOAD/CHECK; never stalls once loading, gaps in byte_valid simply pause assembly.
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   num_words,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [N-1:0]  wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int BPW = N / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIW-1:0] LAST_B  = BIW'(BPW - 1);
    localparam logic [AW:0]    DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    ONE_W   = (AW + 1)'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]     state;
    logic [AW:0]    count;
    logic [AW-1:0]  widx;
    logic [BIW-1:0] bidx;
    logic [7:0]     csum;
    logic [N-1:0]   word_buf;
    logic [N-1:0]   word_next;
    logic           xfer;
    logic           last_word;
    logic           start_bad;

    assign xfer      = byte_valid && byte_ready;
    assign last_word = ({1'b0, widx} == (count - ONE_W));
    assign start_bad = (num_words == '0) || (num_words > DEPTH_W);

    // Partial word with the incoming byte dropped into its little-endian slot.
    always_comb begin
        word_next = word_buf;
        word_next[{bidx, 3'b000} +: 8] = byte_in;
    end

    // Load sequencer: start handling, byte assembly, write pulse, checksum verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            widx       <= '0;
            bidx       <= '0;
            csum       <= '0;
            word_buf   <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        // Any accepted start puts the core back into reset.
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        if (start_bad) begin
                            state      <= S_ERR;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state      <= S_LOAD;
                            count      <= num_words;
                            widx       <= '0;
                            bidx       <= '0;
                            csum       <= '0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        csum     <= csum ^ byte_in;
                        word_buf <= word_next;
                        if (bidx == LAST_B) begin
                            bidx  <= '0;
                            we    <= 1'b1;
                            waddr <= widx;
                            wdata <= word_next;
                            // Index stays on the final word so it never passes DEPTH-1.
                            if (last_word) begin
                                state <= S_CHECK;
                            end else begin
                                widx <= widx + 1'b1;
                            end
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    error      <= 1'b0;
                    cpu_reset  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand-written corner sequences, randomized loads against a reference model.
// Latency: n/a (testbench).
// Backpressure: waits on byte_ready with a bounded cycle budget.
module tb_imem_loader;

    localparam int N     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int BPW   = N / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_words;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Every write the DUT issues, in order of appearance.
    logic [AW-1:0] obs_a[$];
    logic [N-1:0]  obs_d[$];
    logic [7:0]    stream[$];

    always @(negedge clk) begin
        if (we) begin
            obs_a.push_back(waddr);
            obs_d.push_back(wdata);
        end
    end

    typedef struct {
        logic [AW:0]      nw;
        int               nb;
        logic [8:0][7:0]  b;
        int               gap;
        logic             ed;
        logic             ee;
        int               ew;
        logic [N-1:0]     w0;
        logic [N-1:0]     w1;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
    endtask

    // Ends at a negedge with reset low; queues cleared while no write can be pending.
    task automatic do_reset(input bit check);
        @(negedge clk);
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        if (check) check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        obs_a.delete();
        obs_d.delete();
    endtask

    task automatic pulse_start(input logic [AW:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called and returns at a negedge; the transfer happens on the posedge in between.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int c;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        c = 0;
        while (!byte_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (c >= 50) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: byte_ready never rose within 50 cycles");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // gapmode >= 0: fixed gap; -1: 1..3 idle cycles; -2: 0..2 idle cycles.
    task automatic send_range(input int lo, input int hi, input int gapmode);
        for (int i = lo; i < hi; i++) begin
            int g;
            if (gapmode == -1)      g = $urandom_range(3, 1);
            else if (gapmode == -2) g = $urandom_range(2, 0);
            else                    g = gapmode;
            send_byte(stream[i], g);
        end
    endtask

    function automatic logic [7:0] model_csum(input int nbytes);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < nbytes; i++) x = x ^ stream[i];
        return x;
    endfunction

    // Word i is bytes 4i..4i+3 of the stream, lowest byte first.
    task automatic check_writes(input int nw);
        chk("write_count", obs_a.size(), nw);
        for (int i = 0; i < nw && i < obs_a.size(); i++) begin
            logic [N-1:0] w;
            for (int k = 0; k < BPW; k++) w[8*k +: 8] = stream[i*BPW + k];
            chk($sformatf("waddr[%0d]", i), obs_a[i], i);
            chk($sformatf("wdata[%0d]", i), obs_d[i], w);
        end
    endtask

    task automatic check_end(input logic ed, input logic ee);
        repeat (2) @(negedge clk);
        chk("done", done, ed);
        chk("error", error, ee);
        chk("cpu_reset", cpu_reset, !ed);
        chk("busy", busy, 0);
        chk("byte_ready", byte_ready, 0);
    endtask

    logic [8:0][7:0] s1;
    logic [8:0][7:0] s2;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_in    = '0;
        byte_valid = 1'b0;

        s1 = {8'h77, 8'hF8, 8'h01, 8'h80, 8'h03, 8'h8B, 8'h05, 8'h00, 8'h83};
        s2 = s1;
        s2[8] = 8'h76;
        tbl[0] = '{nw: 7'd2,  nb: 9, b: s1, gap: 0,  ed: 1'b1, ee: 1'b0, ew: 2, w0: 32'h8B050083, w1: 32'hF8018003};
        tbl[1] = '{nw: 7'd2,  nb: 9, b: s2, gap: 0,  ed: 1'b0, ee: 1'b1, ew: 2, w0: 32'h8B050083, w1: 32'hF8018003};
        tbl[2] = '{nw: 7'd0,  nb: 0, b: s1, gap: 0,  ed: 1'b0, ee: 1'b1, ew: 0, w0: 32'h0,        w1: 32'h0};
        tbl[3] = '{nw: 7'd65, nb: 0, b: s1, gap: 0,  ed: 1'b0, ee: 1'b1, ew: 0, w0: 32'h0,        w1: 32'h0};
        tbl[4] = '{nw: 7'd2,  nb: 9, b: s1, gap: -1, ed: 1'b1, ee: 1'b0, ew: 2, w0: 32'h8B050083, w1: 32'hF8018003};

        do_reset(1'b1);

        // Table vectors: nominal load, bad checksum, illegal counts, gapped stream.
        for (int t = 0; t < 5; t++) begin
            do_reset(1'b0);
            stream.delete();
            for (int i = 0; i < tbl[t].nb; i++) stream.push_back(tbl[t].b[i]);
            pulse_start(tbl[t].nw);
            if (tbl[t].nb == 0) begin
                chk($sformatf("v%0d_err_latency", t), error, 1);
                byte_valid = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_ready_low", t), byte_ready, 0);
                end
                byte_valid = 1'b0;
            end else begin
                chk($sformatf("v%0d_busy", t), busy, 1);
                send_range(0, tbl[t].nb, tbl[t].gap);
            end
            check_end(tbl[t].ed, tbl[t].ee);
            chk($sformatf("v%0d_nwrites", t), obs_a.size(), tbl[t].ew);
            if (tbl[t].ew > 0 && obs_d.size() >= 2) begin
                chk($sformatf("v%0d_w0", t), obs_d[0], tbl[t].w0);
                chk($sformatf("v%0d_w1", t), obs_d[1], tbl[t].w1);
            end
            check_writes(tbl[t].ew);
        end

        // Reset after the 5th byte: one write kept, outputs to reset values, then a clean reload.
        do_reset(1'b0);
        stream.delete();
        for (int i = 0; i < 9; i++) stream.push_back(s1[i]);
        pulse_start(7'd2);
        send_range(0, 5, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        chk("midreset_nwrites", obs_a.size(), 1);
        if (obs_a.size() >= 1) begin
            chk("midreset_addr0", obs_a[0], 0);
            chk("midreset_data0", obs_d[0], 32'h8B050083);
        end
        @(negedge clk);
        obs_a.delete();
        obs_d.delete();
        pulse_start(7'd2);
        send_range(0, 9, 0);
        check_end(1'b1, 1'b0);
        check_writes(2);

        // Full depth with random data; a start mid-load must be ignored.
        do_reset(1'b0);
        stream.delete();
        for (int i = 0; i < DEPTH * BPW; i++) stream.push_back(8'($urandom));
        stream.push_back(model_csum(DEPTH * BPW));
        pulse_start(7'd64);
        send_range(0, 10, -2);
        pulse_start(7'd0);
        chk("ignored_start_busy", busy, 1);
        chk("ignored_start_err", error, 0);
        send_range(10, DEPTH * BPW + 1, -2);
        check_end(1'b1, 1'b0);
        check_writes(DEPTH);
        pulse_start(7'd1);
        chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);

        // Random loads, half with a corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            int nw;
            bit corrupt;
            logic [7:0] cs;
            do_reset(1'b0);
            nw = $urandom_range(6, 1);
            corrupt = 1'($urandom_range(1, 0));
            stream.delete();
            for (int i = 0; i < nw * BPW; i++) stream.push_back(8'($urandom));
            cs = model_csum(nw * BPW);
            if (corrupt) cs = cs ^ 8'($urandom_range(255, 1));
            stream.push_back(cs);
            pulse_start(7'(nw));
            send_range(0, nw * BPW + 1, -2);
            check_end(!corrupt, corrupt);
            check_writes(nw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
